// File: rtl/pico_pkg.sv
// Shared definitions for the pico core.
// Contents:
//   N, R         data width and register count
//   OUT_ADDR_DEF register address mapped to the output port (r31)
//   IN_ADDR      register address fed from the input port (r30)
//   word_t       one data word
//   raddr_t      one register address
package pico;
  localparam int N            = 8;
  localparam int R            = 32;
  localparam int OUT_ADDR_DEF = 31;
  localparam int IN_ADDR      = 30;

  typedef logic [N-1:0]         word_t;
  typedef logic [$clog2(R)-1:0] raddr_t;
endpackage

// File: rtl/out_port_sync_fifo.sv
// Single-clock FIFO used by out_port.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i         write wdata_i at the tail (caller must not push when full
//                  unless it pops in the same cycle)
//   pop_i          drop the head entry (ignored when empty)
//   wdata_i        tail data
//   rdata_o        head data (raw storage, undefined when empty)
//   full_o         level == DEPTH
//   empty_o        level == 0
//   level_o        entry count, 0..DEPTH
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         wdata_i,
  output T                         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL = (AW + 1)'(DEPTH);

  // Pointers carry one extra MSB so that full (MSBs differ) and empty
  // (pointers equal) are distinguishable without a separate counter.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_pop;

  T mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == FULL_LVL);
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  // A push into a full FIFO with a simultaneous pop overwrites the slot being
  // read, which is safe because the head is read before the edge.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/out_port.sv
// Output port of the pico core: snoops the register-file write bus and
// queues every write to OUT_ADDR for an off-chip sink.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wr_en_i, rd_addr_i,  register-file write bus (shared with rf, not gated)
//   wd_data_i
//   stall_o              FIFO full; core must hold further OUT_ADDR writes
//   ext_data_o           head data, 0 while ext_valid_o is low
//   ext_valid_o          head entry valid
//   ext_ready_i          sink accepts the head this cycle
//   level_o              entry count 0..DEPTH
//   ovf_o                sticky: a write was dropped
//   drop_cnt_o           dropped writes, saturating at 255
//   clr_ovf_i            synchronous clear of ovf_o / drop_cnt_o
//
// Handshake: an entry transfers on a rising edge where ext_valid_o and
// ext_ready_i are both high. ext_valid_o and ext_data_o come from registered
// state only, stay stable until that transfer, and never depend on
// ext_ready_i in the same cycle. ready while valid is low is ignored.
module out_port
  import pico::*;
#(
  parameter int DEPTH    = 4,
  parameter int OUT_ADDR = OUT_ADDR_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  raddr_t                 rd_addr_i,
  input  word_t                  wd_data_i,
  output logic                   stall_o,
  output word_t                  ext_data_o,
  output logic                   ext_valid_o,
  input  logic                   ext_ready_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   ovf_o,
  output logic [7:0]             drop_cnt_o,
  input  logic                   clr_ovf_i
);
  logic  push, pop, drop, fifo_push;
  logic  fifo_full, fifo_empty;
  word_t fifo_head;

  logic       ovf_q, ovf_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign push = wr_en_i & (rd_addr_i == raddr_t'(OUT_ADDR));
  assign pop  = ext_valid_o & ext_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign fifo_push = push & (~fifo_full | pop);
  assign drop      = push & fifo_full & ~pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (word_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .pop_i   (pop),
    .wdata_i (wd_data_i),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign ext_valid_o = ~fifo_empty;
  assign ext_data_o  = fifo_empty ? '0 : fifo_head;
  assign stall_o     = fifo_full;

  // A drop in the same cycle as a clear wins: the clear erases history and
  // the new drop is counted as the first one.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf_i)                 drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr_ovf_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_out_port.sv
module tb_out_port;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       stall;
  logic [7:0] ext_data;
  logic       ext_valid;
  logic       ready;
  logic [2:0] level;
  logic       ovf;
  logic [7:0] drop_cnt;
  logic       clr;

  int checks = 0;
  int errors = 0;

  // Reference model state: queue of words expected on the port, occupancy,
  // overflow flag and drop count.
  logic [7:0] exp_q[$];
  int         m_cnt;
  logic       m_ovf;
  int         m_drops;

  logic       prev_hold;
  logic [7:0] prev_data;

  out_port #(.DEPTH(DEPTH), .OUT_ADDR(31)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_en_i     (wr_en),
    .rd_addr_i   (addr),
    .wd_data_i   (wdata),
    .stall_o     (stall),
    .ext_data_o  (ext_data),
    .ext_valid_o (ext_valid),
    .ext_ready_i (ready),
    .level_o     (level),
    .ovf_o       (ovf),
    .drop_cnt_o  (drop_cnt),
    .clr_ovf_i   (clr)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      bit is_push, is_pop, is_drop;
      is_push = wr_en && (addr == 5'd31);
      is_pop  = (m_cnt > 0) && ready;
      is_drop = 1'b0;
      if (is_push) begin
        if (m_cnt < DEPTH || is_pop) begin
          exp_q.push_back(wdata);
          m_cnt++;
        end else begin
          is_drop = 1'b1;
        end
      end
      if (is_drop) begin
        m_ovf   = 1'b1;
        m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      end else if (clr) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
      if (is_pop) m_cnt--;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      check("level", int'(level), m_cnt);
      check("stall", int'(stall), int'(m_cnt == DEPTH));
      check("valid", int'(ext_valid), int'(m_cnt > 0));
      check("ovf", int'(ovf), int'(m_ovf));
      check("drop_cnt", int'(drop_cnt), m_drops);
      if (prev_hold) begin
        check("hold_valid", int'(ext_valid), 1);
        check("hold_data", int'(ext_data), int'(prev_data));
      end
      if (!ext_valid) check("idle_data", int'(ext_data), 0);
      if (ext_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", int'(ext_data), -1);
        end else begin
          check("pop_data", int'(ext_data), int'(exp_q.pop_front()));
        end
      end
      prev_hold = ext_valid && !ready;
      prev_data = ext_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [7:0] d, input logic c = 1'b0);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    clr   = c;
    cyc();
    wr_en = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_valid"}, int'(ext_valid), 0);
    check({tag, "_data"}, int'(ext_data), 0);
    check({tag, "_stall"}, int'(stall), 0);
    check({tag, "_ovf"}, int'(ovf), 0);
    check({tag, "_drops"}, int'(drop_cnt), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    addr  = '0;
    wdata = '0;
    ready = 1'b0;
    clr   = 1'b0;
    #2;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single write with ready high.
    ready = 1'b1;
    write(5'd31, 8'hA5);
    idle(3);

    // Writes to non-port addresses.
    write(5'd5, 8'h11);
    write(5'd30, 8'h11);
    write(5'd0, 8'h11);
    idle(2);

    // Fill with the sink stalled, then one drop, then drain.
    ready = 1'b0;
    write(5'd31, 8'h01);
    write(5'd31, 8'h02);
    write(5'd31, 8'h03);
    write(5'd31, 8'h04);
    write(5'd31, 8'h05);
    idle(3);
    ready = 1'b1;
    idle(6);

    // Full FIFO with simultaneous push and pop.
    ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) write(5'd31, 8'($urandom_range(0, 255)));
    ready = 1'b1;
    write(5'd31, 8'h06);
    idle(6);

    // Backpressure: random ready over 20 accepted writes.
    for (int n = 0, guard = 0; n < 20 && guard < 400; guard++) begin
      ready = 1'($urandom_range(0, 1));
      if (m_cnt < DEPTH && $urandom_range(0, 2) != 0) begin
        write(5'd31, 8'($urandom_range(0, 255)));
        n++;
      end else begin
        cyc();
      end
    end
    ready = 1'b1;
    idle(6);

    // Drop counter saturation, then clear colliding with a drop.
    ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) write(5'd31, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 300; i++) write(5'd31, 8'($urandom_range(0, 255)));
    write(5'd31, 8'hEE, 1'b1);
    idle(1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    ready = 1'b1;
    idle(6);

    // Random traffic on the whole write bus.
    for (int i = 0; i < 400; i++) begin
      ready = 1'($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      wr_en = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1:    addr = 5'd31;
        2:       addr = 5'd30;
        default: addr = 5'($urandom_range(0, 31));
      endcase
      wdata = 8'($urandom_range(0, 255));
      cyc();
    end
    wr_en = 1'b0;
    clr   = 1'b0;

    // Asynchronous reset in the middle of a cycle with data queued.
    ready = 1'b0;
    write(5'd31, 8'h3C);
    write(5'd31, 8'h5A);
    write(5'd31, 8'h77);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    cyc();
    rst_n = 1'b1;
    ready = 1'b1;
    write(5'd31, 8'hC3);
    idle(6);

    check("final_queue", exp_q.size(), 0);
    check("final_level", int'(level), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
